// File: rtl/spi_slave.sv
// spi_slave: SPI responder for 10-bit command frames with 8-bit read-back.
// Receives a FRAME_W-bit frame on i_mosi while i_ss_n is low and presents it on
// o_rx_data with a one-cycle o_rx_valid pulse. For read commands (top two bits 2'b11)
// it waits for i_tx_valid and then shifts i_tx_data out on o_miso, MSB first.
// o_valid_miso is high for exactly DATA_W cycles.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_ss_n, i_mosi              slave select (active low) and serial data from the master
//   o_miso, o_valid_miso        serial read data and its qualifier
//   o_sready                    idle, a new frame may start
//   o_rx_data, o_rx_valid       last received frame and its update pulse
//   i_tx_data, i_tx_valid       read word from the back-end, sampled only while waiting for it
//   o_frame_err                 pulse when i_ss_n rises before the transfer is complete
module spi_slave #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_ss_n,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_valid_miso,
    output logic               o_sready,
    output logic [FRAME_W-1:0] o_rx_data,
    output logic               o_rx_valid,
    input  logic [DATA_W-1:0]  i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_frame_err
);
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_RX, S_WAIT_TX, S_TX, S_WAIT_SS} state_t;

    state_t             r_state, w_next;
    logic [3:0]         r_cnt, w_cnt;
    logic [FRAME_W-2:0] r_shift, w_shift;
    logic [DATA_W-1:0]  r_tx, w_tx;
    logic               r_miso, w_miso, r_valid_miso, w_valid_miso, r_sready, w_sready;
    logic [FRAME_W-1:0] r_rx_data, w_rx_data;
    logic               r_rx_valid, w_rx_valid, r_frame_err, w_frame_err;
    logic               w_last, w_abort;

    assign w_last  = (r_cnt == 4'd0);
    assign w_abort = i_ss_n && (r_state inside {S_LEAD, S_RX, S_WAIT_TX, S_TX});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_tx         <= '0;
            r_miso       <= 1'b0;
            r_valid_miso <= 1'b0;
            r_sready     <= 1'b1;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt;
            r_shift      <= w_shift;
            r_tx         <= w_tx;
            r_miso       <= w_miso;
            r_valid_miso <= w_valid_miso;
            r_sready     <= w_sready;
            r_rx_data    <= w_rx_data;
            r_rx_valid   <= w_rx_valid;
            r_frame_err  <= w_frame_err;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = i_ss_n ? S_IDLE : S_LEAD;
            S_LEAD:    w_next = i_ss_n ? S_IDLE : S_RX;
            S_RX:      w_next = i_ss_n ? S_IDLE : !w_last ? S_RX :
                                (r_shift[FRAME_W-2 -: 2] == 2'b11) ? S_WAIT_TX : S_WAIT_SS;
            S_WAIT_TX: w_next = i_ss_n ? S_IDLE : i_tx_valid ? S_TX : S_WAIT_TX;
            S_TX:      w_next = i_ss_n ? S_IDLE : w_last ? S_WAIT_SS : S_TX;
            S_WAIT_SS: w_next = i_ss_n ? S_IDLE : S_WAIT_SS;
            default:   w_next = S_IDLE;
        endcase
    end

    // The lead-in is the cycle between ss_n falling and the master's first bit;
    // the edge leaving LEAD is the one that captures that first bit.
    always_comb begin
        w_cnt        = r_cnt;
        w_shift      = r_shift;
        w_tx         = r_tx;
        w_miso       = r_miso;
        w_valid_miso = r_valid_miso;
        w_rx_data    = r_rx_data;
        w_rx_valid   = 1'b0;
        w_frame_err  = w_abort;
        w_sready     = (w_next == S_IDLE);
        if (w_abort) begin
            w_miso       = 1'b0;
            w_valid_miso = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_cnt = 4'(FRAME_W - 1);
                S_LEAD, S_RX: begin
                    if (w_last) begin
                        w_rx_data  = {r_shift, i_mosi};
                        w_rx_valid = 1'b1;
                    end else begin
                        w_shift = {r_shift[FRAME_W-3:0], i_mosi};
                        w_cnt   = r_cnt - 4'd1;
                    end
                end
                S_WAIT_TX: begin
                    if (i_tx_valid) begin
                        w_tx         = {i_tx_data[DATA_W-2:0], 1'b0};
                        w_miso       = i_tx_data[DATA_W-1];
                        w_valid_miso = 1'b1;
                        w_cnt        = 4'(DATA_W - 1);
                    end
                end
                S_TX: begin
                    w_miso       = w_last ? 1'b0 : r_tx[DATA_W-1];
                    w_valid_miso = !w_last;
                    w_tx         = {r_tx[DATA_W-2:0], 1'b0};
                    w_cnt        = w_last ? r_cnt : r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_miso       = r_miso;
    assign o_valid_miso = r_valid_miso;
    assign o_sready     = r_sready;
    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_rx_valid;
    assign o_frame_err  = r_frame_err;
endmodule
